dram_vport_arbiter: RTL and testbench
=====================================

// Module: dram_vport_arbiter
// PURPOSE
//  Memory-side responder for the video fetch port and the CPU port.
//  It splits each 8-slot DRAM cycle window between video and CPU according to video_bw.
//  It issues one DRAM access per granted slot and returns data with strobes to the requester.
//  It sits between the video subsystem / CPU bus bridge and the DRAM controller.
// PARAMETERS
//  AW   21  DRAM word address width
//  DW   16  DRAM data width
// PORTS
//  clk           in   1   28 MHz system clock
//  rst           in   1   synchronous, active-high reset
//  cend          in   1   1-clk pulse marking end of a memory cycle; slot decision point
//  video_go      in   1   video requests a fetch in its slots
//  video_bw      in   2   00=1/8 (slot 0), 01=1/4 (slots 0,4), 10=1/2 (even slots), 11=all slots
//  video_addr    in   AW  video word address; sampled at grant
//  video_next    out  1   1-clk pulse: video address consumed, requester advances
//  video_strobe  out  1   1-clk pulse: video_data valid
//  video_data    out  DW  video read data, held until next video_strobe
//  cpu_req       in   1   CPU access request, held until cpu_next
//  cpu_rnw       in   1   1=read, 0=write
//  cpu_addr      in   AW  CPU word address
//  cpu_wrdata    in   DW  CPU write data
//  cpu_next      out  1   1-clk pulse: CPU request accepted
//  cpu_strobe    out  1   1-clk pulse: CPU access done; cpu_rddata valid for reads
//  cpu_rddata    out  DW  CPU read data, held until next read strobe
//  dram_req      out  1   1-clk pulse: start DRAM access
//  dram_rnw      out  1   access direction, valid with dram_req
//  dram_addr     out  AW  access address, valid with dram_req
//  dram_wrdata   out  DW  write data, valid with dram_req
//  dram_rdy      in   1   1-clk pulse: access complete; dram_rddata valid
//  dram_rddata   in   DW  DRAM read data
// BEHAVIOUR
//  - Reset values:
//    - all pulse outputs 0; video_data, cpu_rddata, dram_addr, dram_wrdata = 0; dram_rnw = 1.
//    - slot counter = 0, state IDLE, owner NONE.
//  - Slot counter (3 bit):
//    - Increments on every cend, wrapping 7->0, whether or not the slot is used.
//    - The decision at a cend applies to the current value (before increment).
//  - Video slot test:
//    - vslot = (bw==11) | (bw==10 & ~slot[0]) | (bw==01 & slot[1:0]==0) | (bw==00 & slot==0).
//  - Decision, taken only on a cend with state IDLE:
//    - If vslot & video_go: grant VIDEO.
//    - Else if cpu_req: grant CPU. CPU may use an unclaimed video slot.
//    - Else: no grant.
//    - CPU never preempts video in a vslot where video_go=1.
//    - Video never takes a non-vslot, even with video_go=1.
//  - Grant timing:
//    - video_next / cpu_next are combinational with the grant, high during the cend clock.
//    - Address and write data are registered on the same edge.
//    - dram_req is high the clock after cend (latency 1). State goes IDLE->BUSY; owner is recorded.
//  - BUSY -> IDLE:
//    - Leave BUSY on the dram_rdy clock.
//    - Next clock: video_strobe (owner VIDEO) or cpu_strobe (owner CPU).
//    - video_data / cpu_rddata are registered from dram_rddata on the dram_rdy clock, so they are valid with the strobe.
//    - Write strobes do not change cpu_rddata.
//  - Simultaneous events:
//    - cend while BUSY: no grant, slot is lost, counter still advances.
//    - dram_rdy and cend in the same clock: return to IDLE first, so that cend CAN grant.
//  - dram_rdy while IDLE: ignored, no strobe.
//  - video_bw change: takes effect at the next cend; an in-flight access completes normally.
//  - rst mid-access:
//    - Return to IDLE and owner NONE immediately.
//    - A following dram_rdy produces no strobe; the slot counter restarts at 0.
// TESTING
//  1. bw=00, video_go=1, cpu_req=0, 16 cends, dram_rdy 3 clks after each dram_req -> exactly 2 video_next (slot 0 twice); video_strobe 1 clk after each dram_rdy with data 16'hA5A5 returned.
//  2. bw=01, video_go=1, cpu_req=1 read addr 21'h1234 held -> video wins slots 0 and 4; cpu_next at slot 1; cpu_strobe with cpu_rddata=dram_rddata.
//  3. bw=11, video_go=0, cpu write 16'hBEEF to 21'h00010 -> grant at first cend; dram_req next clk with dram_rnw=0, addr/data match; cpu_strobe after dram_rdy; cpu_rddata unchanged.
//  4. dram_rdy delayed past next cend -> that cend gives no next pulse, counter advances.
//     dram_rdy coincident with a cend -> grant at that cend.
//  5. rst asserted 1 clk after dram_req -> all outputs 0; later dram_rdy gives no strobe; first post-reset grant uses slot 0.
//  6. Spurious dram_rdy while IDLE -> no video_strobe/cpu_strobe; outputs unchanged.

Source files
------------

// File: rtl/dram_vport_if.sv
// dram_vport_if: video/CPU/DRAM handshake bundle; slave = arbiter side, master = requesters + DRAM side
interface dram_vport_if #(parameter int AW = 21, parameter int DW = 16) ();
  logic          video_go;
  logic [1:0]    video_bw;
  logic [AW-1:0] video_addr;
  logic          video_next;
  logic          video_strobe;
  logic [DW-1:0] video_data;
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wrdata;
  logic          cpu_next;
  logic          cpu_strobe;
  logic [DW-1:0] cpu_rddata;
  logic          dram_req;
  logic          dram_rnw;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wrdata;
  logic          dram_rdy;
  logic [DW-1:0] dram_rddata;
  modport slave (
    input  video_go, video_bw, video_addr, cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, dram_rdy, dram_rddata,
    output video_next, video_strobe, video_data, cpu_next, cpu_strobe, cpu_rddata,
           dram_req, dram_rnw, dram_addr, dram_wrdata
  );
  modport master (
    output video_go, video_bw, video_addr, cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, dram_rdy, dram_rddata,
    input  video_next, video_strobe, video_data, cpu_next, cpu_strobe, cpu_rddata,
           dram_req, dram_rnw, dram_addr, dram_wrdata
  );
endinterface

// File: rtl/dram_vport_arbiter.sv
// dram_vport_arbiter: splits 8-slot DRAM window between video and CPU; ports clk, rst, cend, bus (dram_vport_if.slave)
module dram_vport_arbiter #(
  parameter int AW = 21,
  parameter int DW = 16
) (
  input logic          clk,
  input logic          rst,
  input logic          cend,
  dram_vport_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {NONE, VIDEO, CPU} owner_t;
  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [2:0]    slot_q, slot_d;
  logic          dram_req_q, dram_req_d, dram_rnw_q, dram_rnw_d;
  logic [AW-1:0] dram_addr_q, dram_addr_d;
  logic [DW-1:0] dram_wrdata_q, dram_wrdata_d, video_data_q, video_data_d, cpu_rddata_q, cpu_rddata_d;
  logic          video_strobe_q, video_strobe_d, cpu_strobe_q, cpu_strobe_d;
  logic          vslot, done, free, grant_v, grant_c;
  always_comb begin
    vslot = (bus.video_bw == 2'd3) | (bus.video_bw == 2'd2 & ~slot_q[0]) |
            (bus.video_bw == 2'd1 & slot_q[1:0] == 2'd0) | (bus.video_bw == 2'd0 & slot_q == 3'd0);
    done = state_q == BUSY & bus.dram_rdy;
    // completion frees the port in the same clock so a coincident cend can still grant
    free = state_q == IDLE | done;
    grant_v = ~rst & cend & free & vslot & bus.video_go;
    grant_c = ~rst & cend & free & ~grant_v & bus.cpu_req;
    slot_d = cend ? slot_q + 3'd1 : slot_q;
    state_d = (grant_v | grant_c) ? BUSY : done ? IDLE : state_q;
    owner_d = grant_v ? VIDEO : grant_c ? CPU : done ? NONE : owner_q;
    dram_req_d = grant_v | grant_c;
    dram_rnw_d = grant_v ? 1'b1 : grant_c ? bus.cpu_rnw : dram_rnw_q;
    dram_addr_d = grant_v ? bus.video_addr : grant_c ? bus.cpu_addr : dram_addr_q;
    dram_wrdata_d = grant_c ? bus.cpu_wrdata : dram_wrdata_q;
    video_strobe_d = done & owner_q == VIDEO;
    cpu_strobe_d = done & owner_q == CPU;
    video_data_d = video_strobe_d ? bus.dram_rddata : video_data_q;
    // dram_rnw_q still describes the completing access; writes leave cpu_rddata alone
    cpu_rddata_d = (cpu_strobe_d & dram_rnw_q) ? bus.dram_rddata : cpu_rddata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= NONE;
      slot_q         <= '0;
      dram_req_q     <= 1'b0;
      dram_rnw_q     <= 1'b1;
      dram_addr_q    <= '0;
      dram_wrdata_q  <= '0;
      video_strobe_q <= 1'b0;
      cpu_strobe_q   <= 1'b0;
      video_data_q   <= '0;
      cpu_rddata_q   <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      slot_q         <= slot_d;
      dram_req_q     <= dram_req_d;
      dram_rnw_q     <= dram_rnw_d;
      dram_addr_q    <= dram_addr_d;
      dram_wrdata_q  <= dram_wrdata_d;
      video_strobe_q <= video_strobe_d;
      cpu_strobe_q   <= cpu_strobe_d;
      video_data_q   <= video_data_d;
      cpu_rddata_q   <= cpu_rddata_d;
    end
  end
  assign bus.video_next   = grant_v;
  assign bus.cpu_next     = grant_c;
  assign bus.dram_req     = dram_req_q;
  assign bus.dram_rnw     = dram_rnw_q;
  assign bus.dram_addr    = dram_addr_q;
  assign bus.dram_wrdata  = dram_wrdata_q;
  assign bus.video_strobe = video_strobe_q;
  assign bus.cpu_strobe   = cpu_strobe_q;
  assign bus.video_data   = video_data_q;
  assign bus.cpu_rddata   = cpu_rddata_q;
endmodule

// File: tb/tb_dram_vport_arbiter.sv
// tb_dram_vport_arbiter: directed self-checking bench for dram_vport_arbiter
module tb_dram_vport_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cend = 1'b0;
  logic nv, nc;
  int checks = 0;
  int errors = 0;
  int vn_cnt = 0;
  int vs_cnt = 0;
  dram_vport_if #(.AW(21), .DW(16)) bus ();
  dram_vport_arbiter #(.AW(21), .DW(16)) dut (.clk(clk), .rst(rst), .cend(cend), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic c, input logic r);
    cend = c;
    bus.dram_rdy = r;
    #1;
    nv = bus.video_next;
    nc = bus.cpu_next;
    @(posedge clk);
    #1;
    cend = 1'b0;
    bus.dram_rdy = 1'b0;
  endtask
  task automatic serve(input logic [15:0] d);
    step(1'b0, 1'b0);
    bus.dram_rddata = d;
    step(1'b0, 1'b1);
  endtask
  initial begin
    bus.video_go = 1'b0; bus.video_bw = 2'd0; bus.video_addr = 21'h00100;
    bus.cpu_req = 1'b0; bus.cpu_rnw = 1'b1; bus.cpu_addr = '0; bus.cpu_wrdata = '0;
    bus.dram_rdy = 1'b0; bus.dram_rddata = '0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_dram_req", 32'(bus.dram_req), 32'd0);
    chk("rst_dram_rnw", 32'(bus.dram_rnw), 32'd1);
    chk("rst_dram_addr", 32'(bus.dram_addr), 32'd0);
    chk("rst_video_data", 32'(bus.video_data), 32'd0);
    chk("rst_cpu_rddata", 32'(bus.cpu_rddata), 32'd0);
    rst = 1'b0;
    // 1: bw=00, video only in slot 0
    bus.video_go = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      chk("t1_vnext", 32'(nv), 32'(i % 8 == 0));
      if (nv) begin
        vn_cnt++;
        chk("t1_dram_req", 32'(bus.dram_req), 32'd1);
        chk("t1_dram_addr", 32'(bus.dram_addr), 32'h00100);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        bus.dram_rddata = 16'hA5A5;
        step(1'b0, 1'b1);
        if (bus.video_strobe) vs_cnt++;
        chk("t1_vdata", 32'(bus.video_data), 32'hA5A5);
      end else step(1'b0, 1'b0);
    end
    chk("t1_vnext_count", 32'(vn_cnt), 32'd2);
    chk("t1_vstrobe_count", 32'(vs_cnt), 32'd2);
    // 2: bw=01, CPU read contends with video
    bus.video_bw = 2'd1;
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'h1234;
    step(1'b1, 1'b0);
    chk("t2_s0_vnext", 32'(nv), 32'd1);
    chk("t2_s0_cnext", 32'(nc), 32'd0);
    serve(16'h0101);
    step(1'b1, 1'b0);
    chk("t2_s1_vnext", 32'(nv), 32'd0);
    chk("t2_s1_cnext", 32'(nc), 32'd1);
    chk("t2_s1_req", 32'(bus.dram_req), 32'd1);
    chk("t2_s1_addr", 32'(bus.dram_addr), 32'h1234);
    chk("t2_s1_rnw", 32'(bus.dram_rnw), 32'd1);
    bus.cpu_req = 1'b0;
    serve(16'h5A5A);
    chk("t2_cstrobe", 32'(bus.cpu_strobe), 32'd1);
    chk("t2_crddata", 32'(bus.cpu_rddata), 32'h5A5A);
    chk("t2_vdata_kept", 32'(bus.video_data), 32'h0101);
    step(1'b1, 1'b0);
    chk("t2_s2_vnext", 32'(nv), 32'd0);
    step(1'b1, 1'b0);
    chk("t2_s3_vnext", 32'(nv), 32'd0);
    bus.cpu_req = 1'b1;
    step(1'b1, 1'b0);
    chk("t2_s4_vnext", 32'(nv), 32'd1);
    chk("t2_s4_cnext", 32'(nc), 32'd0);
    bus.cpu_req = 1'b0;
    serve(16'h0404);
    chk("t2_s4_vdata", 32'(bus.video_data), 32'h0404);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    // 3: bw=11, CPU write, video idle
    bus.video_bw = 2'd3; bus.video_go = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = 21'h00010; bus.cpu_wrdata = 16'hBEEF;
    step(1'b1, 1'b0);
    chk("t3_cnext", 32'(nc), 32'd1);
    chk("t3_req", 32'(bus.dram_req), 32'd1);
    chk("t3_rnw", 32'(bus.dram_rnw), 32'd0);
    chk("t3_addr", 32'(bus.dram_addr), 32'h00010);
    chk("t3_wrdata", 32'(bus.dram_wrdata), 32'hBEEF);
    bus.cpu_req = 1'b0;
    serve(16'h1111);
    chk("t3_cstrobe", 32'(bus.cpu_strobe), 32'd1);
    chk("t3_crddata_kept", 32'(bus.cpu_rddata), 32'h5A5A);
    // 4: late and coincident dram_rdy
    bus.video_go = 1'b1;
    step(1'b1, 1'b0);
    chk("t4_grant", 32'(nv), 32'd1);
    step(1'b1, 1'b0);
    chk("t4_busy_vnext", 32'(nv), 32'd0);
    chk("t4_busy_cnext", 32'(nc), 32'd0);
    chk("t4_busy_noreq", 32'(bus.dram_req), 32'd0);
    bus.dram_rddata = 16'h2222;
    step(1'b1, 1'b1);
    chk("t4_coinc_vnext", 32'(nv), 32'd1);
    chk("t4_coinc_strobe", 32'(bus.video_strobe), 32'd1);
    chk("t4_coinc_vdata", 32'(bus.video_data), 32'h2222);
    chk("t4_coinc_req", 32'(bus.dram_req), 32'd1);
    serve(16'h3333);
    bus.video_bw = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk("t4_s4to7_vnext", 32'(nv), 32'd0);
    end
    step(1'b1, 1'b0);
    chk("t4_wrap_vnext", 32'(nv), 32'd1);
    serve(16'h4444);
    // 5: reset mid-access
    bus.video_bw = 2'd3;
    step(1'b1, 1'b0);
    chk("t5_req", 32'(bus.dram_req), 32'd1);
    rst = 1'b1;
    step(1'b0, 1'b0);
    chk("t5_rst_vnext", 32'(nv), 32'd0);
    rst = 1'b0;
    chk("t5_rst_req", 32'(bus.dram_req), 32'd0);
    chk("t5_rst_vdata", 32'(bus.video_data), 32'd0);
    chk("t5_rst_crd", 32'(bus.cpu_rddata), 32'd0);
    chk("t5_rst_addr", 32'(bus.dram_addr), 32'd0);
    chk("t5_rst_rnw", 32'(bus.dram_rnw), 32'd1);
    bus.dram_rddata = 16'h7777;
    step(1'b0, 1'b1);
    chk("t5_late_vstrobe", 32'(bus.video_strobe), 32'd0);
    chk("t5_late_cstrobe", 32'(bus.cpu_strobe), 32'd0);
    bus.video_bw = 2'd0;
    step(1'b1, 1'b0);
    chk("t5_slot0_vnext", 32'(nv), 32'd1);
    serve(16'h6666);
    chk("t5_vdata", 32'(bus.video_data), 32'h6666);
    // 6: spurious dram_rdy while idle
    bus.dram_rddata = 16'hFFFF;
    step(1'b0, 1'b1);
    chk("t6_vstrobe", 32'(bus.video_strobe), 32'd0);
    chk("t6_cstrobe", 32'(bus.cpu_strobe), 32'd0);
    chk("t6_vdata", 32'(bus.video_data), 32'h6666);
    chk("t6_crddata", 32'(bus.cpu_rddata), 32'd0);
    chk("t6_req", 32'(bus.dram_req), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
